// File: rtl/mole_sequencer.sv
// Whack-a-mole round sequencer: blank gap, random target pick, reaction window, one-cycle result.
// Define MOLE_NO_REPEAT_EN to forbid the same target in two consecutive rounds.
module mole_sequencer #(
   parameter int unsigned WINDOW = 25000000,
   parameter int unsigned GAP    = 12500000,
   parameter logic [7:0]  SEED   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] buttons,
   input  logic       game_over,
   output logic [3:0] target,
   output logic       hit,
   output logic       miss,
   output logic       round_active,
   output logic [7:0] rounds
);

   localparam int CNT_W = 26;
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GAP,
      S_PICK,
      S_WINDOW,
      S_RESULT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;
   logic [3:0]       buttons_q;
   logic [3:0]       press;
   logic             pressed;
   logic [7:0]       lfsr;
   logic [3:0]       pick_tgt;
   logic             outcome_hit;

   function automatic logic [3:0] onehot2(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   assign press    = buttons & ~buttons_q;
   assign pressed  = |press;
   assign cnt_zero = (cnt == '0);

   // Free-running LFSR: the pick depends on how long the player took, not just the round index
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr      <= SEED;
         buttons_q <= '0;
      end else begin
         lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         buttons_q <= buttons;
      end
   end

`ifdef MOLE_NO_REPEAT_EN
   logic [3:0] prev_tgt;

   always_comb begin
      pick_tgt = onehot2(lfsr[1:0]);
      if (pick_tgt == prev_tgt)
         pick_tgt = onehot2(lfsr[1:0] + 2'd1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         prev_tgt <= 4'b0000;
      else if (state == S_PICK && !game_over)
         prev_tgt <= pick_tgt;
   end
`else
   assign pick_tgt = onehot2(lfsr[1:0]);
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_GAP;
         S_GAP:    if (game_over) state_nxt = S_IDLE;
                   else if (cnt_zero) state_nxt = S_PICK;
         S_PICK:   state_nxt = game_over ? S_IDLE : S_WINDOW;
         S_WINDOW: if (game_over) state_nxt = S_IDLE;
                   else if (pressed || cnt_zero) state_nxt = S_RESULT;
         S_RESULT: state_nxt = game_over ? S_IDLE : S_GAP;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // A press on the last window cycle wins over the timeout because pressed is tested first
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         target      <= '0;
         rounds      <= '0;
         outcome_hit <= 1'b0;
      end else begin
         if (state == S_IDLE && start)
            rounds <= '0;
         else if (state == S_WINDOW && state_nxt == S_RESULT)
            rounds <= rounds + 8'd1;

         if (state == S_WINDOW && state_nxt == S_RESULT)
            outcome_hit <= (press == target);

         if (state_nxt == S_GAP && state != S_GAP)
            cnt <= GAP_LOAD;
         else if (state == S_PICK)
            cnt <= WIN_LOAD;
         else if ((state == S_GAP || state == S_WINDOW) && !cnt_zero)
            cnt <= cnt - CNT_ONE;

         if (state_nxt != S_WINDOW)
            target <= '0;
         else if (state == S_PICK)
            target <= pick_tgt;
      end
   end

   always_comb begin
      round_active = (state == S_WINDOW);
      hit          = (state == S_RESULT) && outcome_hit;
      miss         = (state == S_RESULT) && !outcome_hit;
   end

endmodule

// File: doc/mole_sequencer.md
MOLE_SEQUENCER -- requirements
Module: mole_sequencer

Interface
REQ-001 Parameter WINDOW, default 25000000: maximum reaction-window length in clk cycles, range 1..2^26-1.
REQ-002 Parameter GAP, default 12500000: blank inter-round interval in clk cycles, range 1..2^26-1.
REQ-003 Parameter SEED, default 8'hA5: LFSR reset value, nonzero.
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  begins a game when sampled high in IDLE; ignored in other states.
REQ-007 buttons  in  4  player buttons, active-high, already synchronized to clk.
REQ-008 game_over  in  1  from the scoring FSM; stops sequencing.
REQ-009 target  out  4  one-hot active target LED, 4'b0000 when none.
REQ-010 hit  out  1  one-cycle pulse: correct button pressed in window.
REQ-011 miss  out  1  one-cycle pulse: wrong button, multiple buttons, or timeout.
REQ-012 round_active  out  1  high while in WINDOW.
REQ-013 rounds  out  8  completed-round count.

Function
REQ-014 States SHALL be IDLE, GAP, PICK, WINDOW, RESULT.
REQ-015 IDLE: start=1 -> GAP with the interval counter loaded to GAP-1 and rounds cleared to 0; otherwise stay.
REQ-016 GAP: counter decrements each cycle; at 0 -> PICK, so GAP lasts exactly GAP cycles.
REQ-017 PICK: lasts 1 cycle; registers target = onehot(lfsr[1:0]); loads counter to WINDOW-1; -> WINDOW.
REQ-018 Start-to-target latency: start sampled in cycle 0 makes target valid in cycle GAP+2.
REQ-019 Press edge: edge = buttons & ~buttons_q, where buttons_q is registered every cycle in all states; a button held on entry to WINDOW does not count.
REQ-020 WINDOW, edge != 0: if edge == target, the outcome is hit; otherwise (wrong or multiple bits) the outcome is miss; -> RESULT.
REQ-021 WINDOW, edge == 0 and counter == 0: the outcome is miss (timeout); -> RESULT; otherwise the counter decrements.
REQ-022 A press on the final window cycle beats the timeout: the outcome is hit if it matches.
REQ-023 RESULT: lasts 1 cycle; hit or miss asserted for exactly this cycle, never both; target cleared to 0; rounds increments, wrapping 255 -> 0; -> GAP (counter reloaded to GAP-1).
REQ-024 Outcome latency: the qualifying edge or timeout in cycle N gives the hit/miss pulse in cycle N+1.
REQ-025 game_over=1 in any non-IDLE state -> IDLE on the next cycle: target=0, no hit/miss pulse, rounds held. If game_over=1 in RESULT, that cycle's pulse is still issued and the next state is IDLE.
REQ-026 LFSR: 8-bit Fibonacci, taps 8,6,5,4, advancing every cycle in every state; never reaches 0.
REQ-027 round_active SHALL equal (state == WINDOW).

Reset
REQ-028 rst=1 at a clock edge -> IDLE; target=0, hit=0, miss=0, round_active=0, rounds=0, counter=0, buttons_q=0, lfsr=SEED.
REQ-029 Reset mid-WINDOW SHALL produce no hit/miss pulse; rst has priority over start and game_over.

Configuration
REQ-030 Macro MOLE_NO_REPEAT_EN defined: in PICK, if onehot(lfsr[1:0]) equals the previous round's target, target SHALL be the next index ((idx+1) mod 4); the previous target resets to 4'b0000.
REQ-031 Macro MOLE_NO_REPEAT_EN undefined: target = onehot(lfsr[1:0]) unconditionally, and no previous-target register exists.

Verification (WINDOW=8, GAP=4, SEED=8'hA5)
REQ-032 Start pulse at cycle 0 -> target one-hot and round_active=1 at cycle 6, and target follows lfsr[1:0] at PICK.
REQ-033 Press the matching bit 3 cycles into WINDOW -> hit=1 for exactly 1 cycle the next cycle, target=0, rounds=1.
REQ-034 No press -> miss=1 exactly 8 cycles after target rises; then target rises again after a 4-cycle GAP plus 1-cycle PICK.
REQ-035 Target=4'b0010 with buttons=4'b0011 pressed together -> miss; a button held since GAP and never released -> timeout miss.
REQ-036 game_over=1 mid-WINDOW -> IDLE next cycle, no pulse; rst mid-WINDOW -> all outputs 0, no pulse.
REQ-037 With MOLE_NO_REPEAT_EN defined, run 200 rounds -> no two consecutive equal targets; with it undefined -> at least one repeat occurs with SEED.
